// File: rtl/div_issue_ctrl.sv
// ---------------------------------------------------------------------------
// div_issue_ctrl
//
// Control stage in front of the multi-cycle M-extension divider.
//  - Decodes DIV/DIVU/REM/REMU and resolves divide-by-zero and signed
//    overflow locally, without starting the divider.
//  - Keeps a one-entry result cache (operands, signedness, quotient and
//    remainder) so a DIV/REM pair on identical operands is served without a
//    second divide.
//  - Sequences the divider start/ready/valid handshake and holds the result
//    until the consumer accepts it.
//
// Ports
//  clk, rst_n       clock, synchronous active-low reset
//  flush            pipeline kill; cancels the in-flight request
//  req_*            request channel (valid/ready, op, rs1, rs2, tag)
//  resp_*           response channel (valid/ready, data, tag)
//  div_start        divider start, qualified by div_ready
//  div_ready        divider idle
//  div_valid        divider result valid (single-cycle pulse)
//  div_error        divider reports divide-by-zero
//  div_is_signed    signedness of the issued operation
//  div_dividend     divider dividend (stable while the divide is pending)
//  div_divisor      divider divisor  (stable while the divide is pending)
//  div_quotient     divider quotient
//  div_remainder    divider remainder
// ---------------------------------------------------------------------------
module div_issue_ctrl #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,

    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [XLEN-1:0]  req_rs1,
    input  logic [XLEN-1:0]  req_rs2,
    input  logic [TAG_W-1:0] req_tag,

    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_data,
    output logic [TAG_W-1:0] resp_tag,

    output logic             div_start,
    input  logic             div_ready,
    input  logic             div_valid,
    input  logic             div_error,
    output logic             div_is_signed,
    output logic [XLEN-1:0]  div_dividend,
    output logic [XLEN-1:0]  div_divisor,
    input  logic [XLEN-1:0]  div_quotient,
    input  logic [XLEN-1:0]  div_remainder
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_BUSY  = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    // Most negative signed value; dividing it by -1 overflows.
    localparam logic [XLEN-1:0] SIGNED_MIN = {1'b1, {(XLEN-1){1'b0}}};

    // Controller state
    logic [2:0]       state_q,     state_d;

    // Latched request
    logic [1:0]       op_q,        op_d;
    logic [XLEN-1:0]  rs1_q,       rs1_d;
    logic [XLEN-1:0]  rs2_q,       rs2_d;
    logic [TAG_W-1:0] tag_q,       tag_d;

    // One-entry result cache
    logic             cache_vld_q,    cache_vld_d;
    logic [XLEN-1:0]  cache_rs1_q,    cache_rs1_d;
    logic [XLEN-1:0]  cache_rs2_q,    cache_rs2_d;
    logic             cache_signed_q, cache_signed_d;
    logic [XLEN-1:0]  cache_quo_q,    cache_quo_d;
    logic [XLEN-1:0]  cache_rem_q,    cache_rem_d;

    // Response holding registers
    logic [XLEN-1:0]  resp_data_q, resp_data_d;
    logic [TAG_W-1:0] resp_tag_q,  resp_tag_d;

    // Request classification
    logic             req_signed;
    logic             req_div_zero;
    logic             req_overflow;
    logic             req_hit;

    // op[1] selects remainder, op[0] selects unsigned.
    function automatic logic [XLEN-1:0] pick_result(
        input logic            is_rem,
        input logic [XLEN-1:0] quo,
        input logic [XLEN-1:0] rem
    );
        return is_rem ? rem : quo;
    endfunction

    // ------------------------------------------------------------------
    // Classification of the incoming request
    // ------------------------------------------------------------------
    always_comb begin
        req_signed   = ~req_op[0];
        req_div_zero = (req_rs2 == '0);
        req_overflow = req_signed && (req_rs1 == SIGNED_MIN) && (req_rs2 == '1);
        req_hit      = cache_vld_q
                       && (cache_rs1_q    == req_rs1)
                       && (cache_rs2_q    == req_rs2)
                       && (cache_signed_q == req_signed);
    end

    // ------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        rs1_d          = rs1_q;
        rs2_d          = rs2_q;
        tag_d          = tag_q;
        cache_vld_d    = cache_vld_q;
        cache_rs1_d    = cache_rs1_q;
        cache_rs2_d    = cache_rs2_q;
        cache_signed_d = cache_signed_q;
        cache_quo_d    = cache_quo_q;
        cache_rem_d    = cache_rem_q;
        resp_data_d    = resp_data_q;
        resp_tag_d     = resp_tag_q;
        div_start      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && !flush) begin
                    op_d  = req_op;
                    rs1_d = req_rs1;
                    rs2_d = req_rs2;
                    tag_d = req_tag;
                    // Resolved locally: the result is loaded straight into
                    // the response register so resp_valid rises next cycle.
                    if (req_div_zero) begin
                        resp_data_d = pick_result(req_op[1], '1, req_rs1);
                        resp_tag_d  = req_tag;
                        state_d     = ST_DONE;
                    end else if (req_overflow) begin
                        resp_data_d = pick_result(req_op[1], req_rs1, '0);
                        resp_tag_d  = req_tag;
                        state_d     = ST_DONE;
                    end else if (req_hit) begin
                        resp_data_d = pick_result(req_op[1], cache_quo_q, cache_rem_q);
                        resp_tag_d  = req_tag;
                        state_d     = ST_DONE;
                    end else begin
                        state_d     = ST_ISSUE;
                    end
                end
            end

            ST_ISSUE: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    div_start = div_ready;
                    if (div_ready) begin
                        state_d = ST_BUSY;
                    end
                end
            end

            ST_BUSY: begin
                if (div_valid) begin
                    if (flush) begin
                        // Result arrives in the kill cycle: drop it outright.
                        state_d = ST_IDLE;
                    end else if (div_error) begin
                        // Divider disagrees with local zero detection; fall
                        // back to the zero-divisor result and keep the cache.
                        resp_data_d = pick_result(op_q[1], '1, rs1_q);
                        resp_tag_d  = tag_q;
                        state_d     = ST_DONE;
                    end else begin
                        cache_vld_d    = 1'b1;
                        cache_rs1_d    = rs1_q;
                        cache_rs2_d    = rs2_q;
                        cache_signed_d = ~op_q[0];
                        cache_quo_d    = div_quotient;
                        cache_rem_d    = div_remainder;
                        resp_data_d    = pick_result(op_q[1], div_quotient, div_remainder);
                        resp_tag_d     = tag_q;
                        state_d        = ST_DONE;
                    end
                end else if (flush) begin
                    // Divider cannot be aborted; wait for its result and drop it.
                    state_d = ST_DRAIN;
                end
            end

            ST_DONE: begin
                if (flush || resp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            ST_DRAIN: begin
                if (div_valid) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A kill invalidates the cache regardless of state; this overrides
        // any cache fill computed above in the same cycle.
        if (flush) begin
            cache_vld_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            op_q           <= '0;
            rs1_q          <= '0;
            rs2_q          <= '0;
            tag_q          <= '0;
            cache_vld_q    <= 1'b0;
            cache_rs1_q    <= '0;
            cache_rs2_q    <= '0;
            cache_signed_q <= 1'b0;
            cache_quo_q    <= '0;
            cache_rem_q    <= '0;
            resp_data_q    <= '0;
            resp_tag_q     <= '0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            rs1_q          <= rs1_d;
            rs2_q          <= rs2_d;
            tag_q          <= tag_d;
            cache_vld_q    <= cache_vld_d;
            cache_rs1_q    <= cache_rs1_d;
            cache_rs2_q    <= cache_rs2_d;
            cache_signed_q <= cache_signed_d;
            cache_quo_q    <= cache_quo_d;
            cache_rem_q    <= cache_rem_d;
            resp_data_q    <= resp_data_d;
            resp_tag_q     <= resp_tag_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: registered or decoded from state only
    // ------------------------------------------------------------------
    assign req_ready     = (state_q == ST_IDLE);
    assign resp_valid    = (state_q == ST_DONE);
    assign resp_data     = resp_data_q;
    assign resp_tag      = resp_tag_q;
    assign div_is_signed = ~op_q[0];
    assign div_dividend  = rs1_q;
    assign div_divisor   = rs2_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_div_issue_ctrl
//
// Bench for div_issue_ctrl with a behavioural divider (random latency and
// random ready back-pressure) and a reference model that derives each
// response from the RISC-V division rules plus a one-entry cache record.
// ---------------------------------------------------------------------------
module tb_div_issue_ctrl;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [1:0]       req_op = '0;
    logic [XLEN-1:0]  req_rs1 = '0;
    logic [XLEN-1:0]  req_rs2 = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic             resp_valid;
    logic             resp_ready = 1'b0;
    logic [XLEN-1:0]  resp_data;
    logic [TAG_W-1:0] resp_tag;
    logic             div_start;
    logic             div_ready;
    logic             div_valid;
    logic             div_error;
    logic             div_is_signed;
    logic [XLEN-1:0]  div_dividend;
    logic [XLEN-1:0]  div_divisor;
    logic [XLEN-1:0]  div_quotient;
    logic [XLEN-1:0]  div_remainder;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    div_issue_ctrl #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_rs1       (req_rs1),
        .req_rs2       (req_rs2),
        .req_tag       (req_tag),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_data     (resp_data),
        .resp_tag      (resp_tag),
        .div_start     (div_start),
        .div_ready     (div_ready),
        .div_valid     (div_valid),
        .div_error     (div_error),
        .div_is_signed (div_is_signed),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder)
    );

    // ---------------- behavioural divider ----------------
    logic        dv_busy;
    logic        dv_valid;
    logic        dv_rnd_block;
    logic        dv_block = 1'b0;
    int          dv_cnt;
    logic [63:0] dv_res;

    function automatic logic [63:0] raw_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] q, r;
        if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    assign div_ready     = !dv_busy && !dv_block && !dv_rnd_block;
    assign div_valid     = dv_valid;
    assign div_error     = 1'b0;
    assign div_quotient  = dv_res[63:32];
    assign div_remainder = dv_res[31:0];

    always @(posedge clk) begin
        if (!rst_n) begin
            dv_busy      <= 1'b0;
            dv_valid     <= 1'b0;
            dv_cnt       <= 0;
            dv_rnd_block <= 1'b0;
            dv_res       <= '0;
        end else begin
            dv_valid     <= 1'b0;
            dv_rnd_block <= ($urandom_range(0, 3) == 0);
            if (dv_busy) begin
                if (dv_cnt == 0) begin
                    dv_busy  <= 1'b0;
                    dv_valid <= 1'b1;
                end else begin
                    dv_cnt <= dv_cnt - 1;
                end
            end else if (div_start && div_ready) begin
                dv_busy <= 1'b1;
                dv_cnt  <= int'($urandom_range(1, 4));
                dv_res  <= raw_div(div_dividend, div_divisor, div_is_signed);
            end
        end
    end

    // Issue monitor: counts divider starts and records their operands.
    int          n_issue = 0;
    logic [31:0] iss_a = '0;
    logic [31:0] iss_b = '0;
    logic        iss_s = 1'b0;

    always @(posedge clk) begin
        if (rst_n && div_start && div_ready) begin
            n_issue <= n_issue + 1;
            iss_a   <= div_dividend;
            iss_b   <= div_divisor;
            iss_s   <= div_is_signed;
        end
    end

    // ---------------- reference model ----------------
    logic        ref_cv = 1'b0;
    logic [31:0] ref_a = '0;
    logic [31:0] ref_b = '0;
    logic        ref_s = 1'b0;

    function automatic logic ref_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'h0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 32'h0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = 32'h0;
        end else if (!op[0]) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return op[1] ? r : q;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction. blk holds div_ready low for that many cycles
    // after accept (only meaningful for requests that go to the divider).
    task automatic do_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input int blk, input int stall,
                          output logic [31:0] got);
        int          n0;
        int          lat;
        logic        sgn;
        logic        exp_issue;
        logic [31:0] exp_d;
        sgn       = !op[0];
        exp_issue = !ref_special(op, a, b) && !(ref_cv && ref_a == a && ref_b == b && ref_s == sgn);
        exp_d     = ref_result(op, a, b);
        got       = '0;

        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_rs1   = a;
        req_rs2   = b;
        req_tag   = tag;
        dv_block  = (blk > 0);
        n0        = n_issue;
        step();
        req_valid = 1'b0;

        for (int i = 0; i < blk; i++) begin
            check("blk_start", 32'(div_start), 32'd0);
            check("blk_dividend", div_dividend, a);
            check("blk_divisor", div_divisor, b);
            step();
        end
        dv_block = 1'b0;

        lat = 1 + blk;
        while (!resp_valid && lat < 200) begin
            step();
            lat++;
        end
        if (!resp_valid) begin
            check("resp_timeout", 32'(resp_valid), 32'd1);
            return;
        end
        if (!exp_issue) check("local_latency", 32'(lat), 32'd1);
        check("issue_count", 32'(n_issue - n0), 32'(exp_issue));
        if (exp_issue) begin
            check("iss_dividend", iss_a, a);
            check("iss_divisor", iss_b, b);
            check("iss_signed", 32'(iss_s), 32'(sgn));
        end
        check("resp_data", resp_data, exp_d);
        check("resp_tag", 32'(resp_tag), 32'(tag));

        for (int i = 0; i < stall; i++) begin
            step();
            check("stall_valid", 32'(resp_valid), 32'd1);
            check("stall_data", resp_data, exp_d);
            check("stall_tag", 32'(resp_tag), 32'(tag));
        end
        got        = resp_data;
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check("post_hs_valid", 32'(resp_valid), 32'd0);
        check("post_hs_ready", 32'(req_ready), 32'd1);

        if (exp_issue) begin
            ref_cv = 1'b1;
            ref_a  = a;
            ref_b  = b;
            ref_s  = sgn;
        end
    endtask

    // Accept a divider-bound request and return once the divider has started.
    task automatic start_miss(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int n0;
        int k;
        n0        = n_issue;
        req_valid = 1'b1;
        req_op    = op;
        req_rs1   = a;
        req_rs2   = b;
        req_tag   = 5'd3;
        step();
        req_valid = 1'b0;
        k = 0;
        while (n_issue == n0 && k < 100) begin
            step();
            k++;
        end
        check("miss_started", 32'(n_issue - n0), 32'd1);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [31:0] got;
        logic [31:0] a, b, pa, pb;
        logic [1:0]  op;
        int          n0;
        int          k;
        pa = 32'd17;
        pb = 32'd5;

        repeat (3) step();
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_div_start", 32'(div_start), 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_resp_tag", 32'(resp_tag), 32'd0);
        rst_n = 1'b1;
        step();

        // Signed divide then remainder from the cache
        do_req(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd9, 0, 0, got);
        check("tp_div_neg", got, 32'hFFFF_FFFD);
        do_req(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd10, 0, 0, got);
        check("tp_rem_hit", got, 32'hFFFF_FFFF);

        // Divide by zero
        do_req(2'b01, 32'd100, 32'd0, 5'd11, 0, 1, got);
        check("tp_divu_zero", got, 32'hFFFF_FFFF);
        do_req(2'b11, 32'd100, 32'd0, 5'd12, 0, 0, got);
        check("tp_remu_zero", got, 32'd100);

        // Signed overflow
        do_req(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 0, 0, got);
        check("tp_div_ovf", got, 32'h8000_0000);
        do_req(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 0, 0, got);
        check("tp_rem_ovf", got, 32'd0);

        // Divider back-pressure and consumer stall
        do_req(2'b01, 32'd20, 32'd3, 5'd15, 3, 4, got);
        check("tp_divu_stall", got, 32'd6);

        // Flush while the divider is busy
        do_req(2'b01, 32'd1000, 32'd7, 5'd16, 0, 0, got);
        start_miss(2'b00, 32'd5000, 32'd13);
        flush = 1'b1;
        step();
        flush  = 1'b0;
        ref_cv = 1'b0;
        check("drain_req_ready", 32'(req_ready), 32'd0);
        k = 0;
        while (!req_ready && k < 50) begin
            check("drain_resp_valid", 32'(resp_valid), 32'd0);
            step();
            k++;
        end
        check("drain_exit", 32'(req_ready), 32'd1);
        check("drain_no_resp", 32'(resp_valid), 32'd0);
        do_req(2'b00, 32'd5000, 32'd13, 5'd17, 0, 0, got);
        do_req(2'b01, 32'd1000, 32'd7, 5'd18, 0, 0, got);

        // Flush in ISSUE: no start in the kill cycle
        n0        = n_issue;
        dv_block  = 1'b1;
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_rs1   = 32'd555;
        req_rs2   = 32'd9;
        step();
        req_valid = 1'b0;
        flush     = 1'b1;
        dv_block  = 1'b0;
        #1;
        check("flush_issue_start", 32'(div_start), 32'd0);
        step();
        flush  = 1'b0;
        ref_cv = 1'b0;
        check("flush_issue_idle", 32'(req_ready), 32'd1);
        check("flush_issue_count", 32'(n_issue - n0), 32'd0);

        // Flush in DONE drops the response
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_rs1   = 32'd42;
        req_rs2   = 32'd0;
        step();
        req_valid = 1'b0;
        check("flush_done_pre", 32'(resp_valid), 32'd1);
        flush = 1'b1;
        step();
        flush  = 1'b0;
        ref_cv = 1'b0;
        check("flush_done_valid", 32'(resp_valid), 32'd0);
        check("flush_done_ready", 32'(req_ready), 32'd1);

        // Reset during BUSY
        do_req(2'b01, 32'd77, 32'd5, 5'd19, 0, 0, got);
        start_miss(2'b01, 32'd999, 32'd4);
        rst_n = 1'b0;
        step();
        check("rstb_req_ready", 32'(req_ready), 32'd1);
        check("rstb_resp_valid", 32'(resp_valid), 32'd0);
        check("rstb_div_start", 32'(div_start), 32'd0);
        rst_n  = 1'b1;
        ref_cv = 1'b0;
        step();
        do_req(2'b01, 32'd77, 32'd5, 5'd20, 0, 0, got);

        // Randomized traffic with deliberate repeats and special operands
        for (int t = 0; t < 60; t++) begin
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0:       begin a = $urandom(); b = 32'd0; end
                1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2, 3, 4: begin a = pa; b = pb; end
                5:       begin a = $urandom(); b = 32'($urandom_range(1, 9)); end
                default: begin a = $urandom(); b = $urandom(); end
            endcase
            do_req(op, a, b, 5'($urandom_range(0, 31)), 0, int'($urandom_range(0, 2)), got);
            pa = a;
            pb = b;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- Upstream control stage for the M-extension divide path; sits between the execute-stage issue logic and the multi-cycle signed/unsigned divider.
- Decodes DIV/DIVU/REM/REMU and resolves RISC-V special cases (divide-by-zero, signed overflow) locally.
- Serves a back-to-back DIV/REM pair with identical operands from a one-entry result cache.
- Sequences the divider start/ready/valid handshake and holds the result until the consumer accepts it.

Parameters:
- XLEN, 32, operand/result width.
- TAG_W, 5, width of the request tag (destination register index) carried to the response.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  pipeline kill; cancels the in-flight request.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- req_rs1  in  XLEN  dividend.
- req_rs2  in  XLEN  divisor.
- req_tag  in  TAG_W  opaque tag.
- resp_valid  out  1  result present.
- resp_ready  in  1  consumer accepts the result.
- resp_data  out  XLEN  quotient or remainder, selected by op.
- resp_tag  out  TAG_W  tag of the request.
- div_start  out  1  divider start.
- div_ready  in  1  divider idle.
- div_valid  in  1  divider result valid (single-cycle pulse).
- div_error  in  1  divider reports divide-by-zero.
- div_is_signed  out  1  signed operation.
- div_dividend  out  XLEN  divider dividend.
- div_divisor  out  XLEN  divider divisor.
- div_quotient  in  XLEN  divider quotient.
- div_remainder  in  XLEN  divider remainder.

Behaviour:
- States: IDLE, ISSUE, BUSY, DONE, DRAIN.
- Reset values: state=IDLE; cache_vld=0; req_ready=1; resp_valid=0; div_start=0; resp_data, resp_tag and operand registers all 0.
- req_ready=1 only in IDLE. All other outputs are registered or decoded from state; no combinational path from req_* to resp_*.
- Accept (IDLE, req_valid && !flush):
  - Latch op, rs1, rs2 and tag.
  - signed = !op[0].
  - Classify the request:
    - Zero divisor (rs2==0): quotient=all ones; remainder=rs1.
    - Signed overflow (signed && rs1==1<<(XLEN-1) && rs2==all ones): quotient=rs1; remainder=0.
    - Cache hit (cache_vld && rs1, rs2 and signedness all equal the cached values): use the cached quotient/remainder.
  - Special case or hit -> DONE next cycle; resp_valid rises 1 cycle after accept.
  - Otherwise -> ISSUE.
- ISSUE:
  - div_start = div_ready.
  - div_dividend, div_divisor and div_is_signed are driven from the latched registers and stay stable until div_valid.
  - div_start && div_ready -> BUSY.
- BUSY:
  - On div_valid, capture div_quotient/div_remainder into the cache, set cache_vld=1, -> DONE.
  - If div_error is asserted with div_valid, apply the zero-divisor rule instead and leave cache_vld unchanged. Unreachable in correct operation; verification flags it.
- DONE:
  - resp_valid=1.
  - resp_data = quotient for op[1]=0, remainder for op[1]=1.
  - resp_valid && resp_ready -> IDLE.
  - resp_data and resp_tag hold stable while stalled.
- Special-case results never write the cache.
- flush has priority over every other event in the same cycle, and always clears cache_vld:
  - IDLE: request not accepted.
  - ISSUE: -> IDLE, no div_start emitted that cycle.
  - DONE: resp_valid drops next cycle, result discarded, -> IDLE.
  - BUSY: -> DRAIN.
  - DRAIN: no effect.
- DRAIN: req_ready=0, resp_valid=0; on div_valid discard the result -> IDLE.
- flush and div_valid in the same BUSY cycle: result discarded, -> IDLE directly.
- Reset asserted mid-operation: immediate return to reset values. The divider is reset by the same rst_n, so no drain is needed.
- Throughput: one divide in flight; a new accept is possible the cycle after the DONE handshake.

Test Plan:
- DIV rs1=-7 (0xFFFFFFF9), rs2=2; divider returns q=0xFFFFFFFD, r=0xFFFFFFFF -> div_is_signed=1, resp_data=0xFFFFFFFD with tag preserved. A following REM with the same operands -> cache hit, resp_valid 1 cycle after accept, data=0xFFFFFFFF, no div_start.
- DIVU rs1=100, rs2=0 -> no div_start, resp_data=0xFFFFFFFF; REMU with the same operands -> resp_data=100.
- DIV rs1=0x80000000, rs2=0xFFFFFFFF -> resp_data=0x80000000; REM with the same operands -> 0; no div_start for either.
- DIVU 20/3 with div_ready low for 3 cycles -> div_start held, operands stable; resp_valid held with resp_ready low for 4 cycles; data=6 stable throughout.
- flush asserted in BUSY -> DRAIN, req_ready=0 until div_valid, no resp_valid; the next DIV with the same operands misses the cache and issues div_start.
- rst_n low during BUSY -> next cycle req_ready=1, resp_valid=0, div_start=0, cache_vld=0.
